execute_muldiv: RTL
===================

Name: execute_muldiv

Overview:
- Parametrised, iterative RV64M multiply/divide unit for the execute stage.
- Sits beside the single-cycle ALU. Decode/issue hands it operands (already forwarded) with a tag; the result returns via a valid/ready handshake to the memory-stage mux.
- Stalls the pipeline through in_ready/busy. Supports XLEN-wide and 32-bit W-variant operations, and pipeline flush mid-operation.

Parameters:
XLEN, 64, datapath width (32 or 64; W ops legal only when 64)
TAGW, 5, width of the opaque tag (destination register) carried through

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request this cycle
in_op  in  3  md_op_t: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
in_w  in  1  W variant: use low 32 bits of operands, sign-extend 32-bit result
in_src1  in  XLEN  rs1 value (post-forwarding)
in_src2  in  XLEN  rs2 value (post-forwarding)
in_tag  in  TAGW  tag returned with the result
flush  in  1  kill in-flight operation
out_valid  out  1  result valid
out_ready  in  1  consumer takes the result
out_data  out  XLEN  result
out_tag  out  TAGW  tag of the result
busy  out  1  state != IDLE

Behaviour:
- Reset (async, reset_n=0): state=IDLE, counter=0, all datapath registers=0. out_valid=0, out_data=0, out_tag=0, busy=0. in_ready=1 once reset is released.
- States: IDLE, CALC, FIX, DONE.
- in_ready=1 only in IDLE and when flush=0. A request is accepted on a clock edge where in_valid&&in_ready.
- Accept:
  - Latch op, w, tag.
  - N = in_w ? 32 : XLEN.
  - Operands: W ops take the low 32 bits, sign- or zero-extended per op signedness.
  - Signed ops store magnitudes plus result-sign bits.
  - Next state is CALC with counter=N-1.
  - Special case: divide/remainder by zero, or signed overflow (most-negative / -1 at the active width), goes directly to FIX.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add into a 2N-bit product.
  - Divide: restoring shift-subtract.
  - Counter decrements; at counter==0 the next state is FIX.
- FIX: apply sign correction, select the result, sign-extend from bit 31 when w. Next state is DONE.
  - MUL returns the low N bits. MULH/MULHSU/MULHU return the high N bits.
  - DIV/DIVU return the quotient. REM/REMU return the remainder; the remainder takes the dividend's sign.
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Overflow: quotient = dividend, remainder = 0.
- DONE: out_valid=1 with out_data/out_tag held stable until out_ready=1. The handshake edge returns the unit to IDLE. No new accept occurs in DONE.
- Latency: out_valid rises N+2 cycles after the accepting edge (66 for a 64-bit op, 34 for a W op). Special cases take 2 cycles.
- flush=1: the next state is IDLE from any state and out_valid drops on the next edge. A flush takes priority over out_ready and in_valid in the same cycle (nothing is accepted or delivered).
- out_data is registered; no combinational path from in_* to out_*.

Optional Feature:
- MULDIV_FAST_MUL_EN defined: MUL* ops use a single-cycle combinational 2N-bit multiply in CALC, so multiply latency is 2 cycles. Divides are unchanged.
- Undefined: all ops are iterative as described above.

Decomposition:
- pipes package: md_op_t enum; md_req_t/md_resp_t structs (op, w, src1, src2, tag / data, tag).
- common package: the word_t width constant.
- One sub-module, muldiv_core: the shift-add/shift-subtract datapath and counter. execute_muldiv keeps the FSM, handshake, sign fix and W extension.

Test Plan:
- MUL, src1=7, src2=-3 (XLEN=64) -> out_data=0xFFFFFFFFFFFFFFEB, out_valid exactly 66 cycles after accept.
- DIV w=1, src1=0x80000000, src2=-1 -> overflow path, out_data=0xFFFFFFFF80000000 after 2 cycles. Same operands with REMW -> 0.
- DIVU, src2=0, src1=0x1234 -> out_data=0xFFFFFFFFFFFFFFFF. REMU with the same operands -> 0x1234.
- MULHU, src1=src2=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE. out_ready held 0 for 5 cycles -> data/tag stable, in_ready=0 throughout.
- flush asserted 10 cycles into a DIV, with in_valid=1 in the same cycle -> no accept; IDLE next cycle; no out_valid; next request completes correctly.
- reset_n pulsed low mid-CALC, asynchronously between edges -> out_valid/busy cleared immediately; in_ready=1 after release.

Source files
------------

// File: rtl/execute_muldiv_pkg.sv
// execute_muldiv_pkg: shared word width and the pipe-level request/response
// types for the execute-stage multiply/divide unit.
package execute_muldiv_pkg;

  // Common: architectural word width.
  localparam int unsigned WORD_W = 64;
  typedef logic [WORD_W-1:0] word_t;

  // Pipes: operation encoding and request/response bundles.
  localparam int unsigned TAG_W = 5;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_t;

  typedef struct packed {
    md_op_t           op;
    logic             w;
    word_t            src1;
    word_t            src2;
    logic [TAG_W-1:0] tag;
  } md_req_t;

  typedef struct packed {
    word_t            data;
    logic [TAG_W-1:0] tag;
  } md_resp_t;

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
  function automatic logic src1_signed(input md_op_t op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is treated as signed by MULH, DIV and REM.
  function automatic logic src2_signed(input md_op_t op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/execute_muldiv_core.sv
// muldiv_core: radix-2 iterative datapath on operand magnitudes.
// Multiply is an MSB-first shift-add into a double-width product; divide is
// restoring shift-subtract. The counter doubles as the operand bit index, so
// 32-bit and full-width operations share the same step logic.
// MULDIV_FAST_MUL_EN adds a combinational full-width product output.
module muldiv_core #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned CW   = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   load_a,
  input  logic [XLEN-1:0]   load_b,
  input  logic [CW-1:0]     load_cnt,
  output logic              last,
  output logic [XLEN-1:0]   opa,
`ifdef MULDIV_FAST_MUL_EN
  output logic [2*XLEN-1:0] fast_prod,
`endif
  output logic [2*XLEN-1:0] prod,
  output logic [XLEN-1:0]   quo,
  output logic [XLEN-1:0]   rem
);

  logic [XLEN-1:0]   opb;
  logic [CW-1:0]     cnt;
  logic [XLEN:0]     trial;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] prod_next;

  // One radix-2 step: partial remainder trial subtract and product shift-add.
  always_comb begin
    trial     = {rem, opa[cnt]};
    diff      = trial - {1'b0, opb};
    prod_next = {prod[2*XLEN-2:0], 1'b0} + (opb[cnt] ? {{XLEN{1'b0}}, opa} : '0);
  end

  // Operand, counter and accumulator registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opa  <= '0;
      opb  <= '0;
      cnt  <= '0;
      prod <= '0;
      quo  <= '0;
      rem  <= '0;
    end else if (load) begin
      opa  <= load_a;
      opb  <= load_b;
      cnt  <= load_cnt;
      prod <= '0;
      quo  <= '0;
      rem  <= '0;
    end else if (step) begin
      cnt <= cnt - CW'(1);
      if (is_div) begin
        // diff MSB set means the trial subtraction borrowed: restore.
        if (!diff[XLEN]) begin
          rem      <= diff[XLEN-1:0];
          quo[cnt] <= 1'b1;
        end else begin
          rem <= trial[XLEN-1:0];
        end
      end else begin
        prod <= prod_next;
      end
    end
  end

  assign last = (cnt == '0);

`ifdef MULDIV_FAST_MUL_EN
  assign fast_prod = {{XLEN{1'b0}}, opa} * {{XLEN{1'b0}}, opb};
`endif

endmodule

// File: rtl/execute_muldiv.sv
// execute_muldiv: iterative RV64M multiply/divide unit for the execute stage.
// Owns the FSM, valid/ready handshake, sign correction and W-variant
// extension; the shift-add/shift-subtract datapath lives in muldiv_core.
// Optional: MULDIV_FAST_MUL_EN makes MUL* ops a single combinational step.
module execute_muldiv
  import execute_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned TAGW = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic            in_w,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [TAGW-1:0] in_tag,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [TAGW-1:0] out_tag,
  output logic            busy
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned SH = XLEN - 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x);
    return XLEN'($signed(x << SH) >>> SH);
  endfunction

  function automatic logic [XLEN-1:0] zext_w(input logic [XLEN-1:0] x);
    return (x << SH) >> SH;
  endfunction

  logic [1:0]        state;
  md_op_t            req_op;
  md_op_t            op_q;
  logic              w_q;
  logic [TAGW-1:0]   tag_q;
  logic              neg_res_q;
  logic              neg_a_q;
  logic              divz_q;
  logic              ovf_q;

  logic [XLEN-1:0]   ext1, ext2, mag1, mag2, min_val;
  logic              neg1, neg2, req_divz, req_ovf;
  logic              accept;

  logic              core_last;
  logic [XLEN-1:0]   opa, quo, rem;
  logic [2*XLEN-1:0] prod, prod_src, prod_s;
  logic [XLEN-1:0]   dividend, res, fix_data;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
`endif

  assign req_op    = md_op_t'(in_op);
  assign in_ready  = reset_n && (state == S_IDLE) && !flush;
  assign accept    = (state == S_IDLE) && in_valid && !flush;
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign out_tag   = tag_q;

  // Request decode: active-width extension, magnitudes and special cases.
  always_comb begin
    ext1     = in_w ? (src1_signed(req_op) ? sext_w(in_src1) : zext_w(in_src1)) : in_src1;
    ext2     = in_w ? (src2_signed(req_op) ? sext_w(in_src2) : zext_w(in_src2)) : in_src2;
    neg1     = src1_signed(req_op) && ext1[XLEN-1];
    neg2     = src2_signed(req_op) && ext2[XLEN-1];
    mag1     = neg1 ? -ext1 : ext1;
    mag2     = neg2 ? -ext2 : ext2;
    min_val  = in_w ? sext_w(XLEN'(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
    req_divz = req_op[2] && (ext2 == '0);
    req_ovf  = ((req_op == MD_DIV) || (req_op == MD_REM)) && (ext1 == min_val) && (ext2 == '1);
  end

  muldiv_core #(
    .XLEN(XLEN),
    .CW  (CW)
  ) u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (accept),
    .step     ((state == S_CALC) && !flush),
    .is_div   (op_q[2]),
    .load_a   (mag1),
    .load_b   (mag2),
    .load_cnt (in_w ? CW'(31) : CW'(XLEN - 1)),
    .last     (core_last),
    .opa      (opa),
`ifdef MULDIV_FAST_MUL_EN
    .fast_prod(fast_prod),
`endif
    .prod     (prod),
    .quo      (quo),
    .rem      (rem)
  );

  // Result fix-up: sign correction, special-case override, W extension.
  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    prod_src = (state == S_CALC) ? fast_prod : prod;
`else
    prod_src = prod;
`endif
    prod_s   = neg_res_q ? -prod_src : prod_src;
    // The original dividend is rebuilt from its stored magnitude and sign.
    dividend = neg_a_q ? -opa : opa;
    case (op_q)
      MD_MUL:                       res = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: res = w_q ? XLEN'(prod_s >> 32) : prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              res = divz_q ? '1 : ovf_q ? dividend : (neg_res_q ? -quo : quo);
      default:                      res = divz_q ? dividend : ovf_q ? '0 : (neg_a_q ? -rem : rem);
    endcase
    fix_data = w_q ? sext_w(res) : res;
  end

  // Control FSM and request/result registers; flush wins over everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      op_q      <= MD_MUL;
      w_q       <= 1'b0;
      tag_q     <= '0;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      divz_q    <= 1'b0;
      ovf_q     <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q      <= req_op;
            w_q       <= in_w;
            tag_q     <= in_tag;
            neg_res_q <= neg1 ^ neg2;
            neg_a_q   <= neg1;
            divz_q    <= req_divz;
            ovf_q     <= req_ovf;
            state     <= (req_divz || req_ovf) ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
`ifdef MULDIV_FAST_MUL_EN
          // Fast multiply: the fix-up reads the combinational product directly.
          if (!op_q[2]) begin
            out_data <= fix_data;
            state    <= S_DONE;
          end else
`endif
          if (core_last) state <= S_FIX;
        end
        S_FIX: begin
          out_data <= fix_data;
          state    <= S_DONE;
        end
        default: begin
          if (out_ready) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
